// File: rtl/dvp_rx_pkg.sv
// rtl/dvp_rx_pkg.sv - shared state encoding and field-index helpers for the DVP RX FSM
package dvp_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_FRM = 2'd1,
        ST_CAPTURE  = 2'd2
    } state_e;

    function automatic int vsync_bit(input int pxl_info_w);
        return pxl_info_w - 1;
    endfunction

    function automatic int hsync_bit(input int pxl_info_w);
        return pxl_info_w - 2;
    endfunction

    function automatic bit bpp_legal(input int bpp);
        return (bpp >= 1) && (bpp <= 4);
    endfunction

endpackage

// File: rtl/dvp_rx_fsm_if.sv
// rtl/dvp_rx_fsm_if.sv - FIFO-side and pixel-side handshake bundle for the DVP RX FSM
interface dvp_rx_fsm_if #(
    parameter int DVP_DATA_W = 8,
    parameter int BPP        = 2
);
    localparam int PXL_INFO_W = DVP_DATA_W + 2;
    localparam int PXL_W      = DVP_DATA_W * BPP;

    logic [PXL_INFO_W-1:0] pxl_i;
    logic                  pxl_vld_i;
    logic                  pxl_rdy_o;
    logic [PXL_W-1:0]      pix_o;
    logic                  pix_sof_o;
    logic                  pix_sol_o;
    logic                  pix_vld_o;
    logic                  pix_rdy_i;

    modport slave (
        input  pxl_i, pxl_vld_i, pix_rdy_i,
        output pxl_rdy_o, pix_o, pix_sof_o, pix_sol_o, pix_vld_o
    );

    modport master (
        output pxl_i, pxl_vld_i, pix_rdy_i,
        input  pxl_rdy_o, pix_o, pix_sof_o, pix_sol_o, pix_vld_o
    );
endinterface

// File: rtl/pxl_out_reg.sv
// rtl/pxl_out_reg.sv - one-entry valid/ready register slice for tagged pixels
module pxl_out_reg #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o,
    input  logic         rdy_i
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // The producer only loads when the slot is empty or being drained this cycle.
    always_comb begin
        vld_d  = load_i | (vld_q & ~rdy_i);
        data_d = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

// File: rtl/dvp_rx_fsm.sv
// rtl/dvp_rx_fsm.sv - frame-locking DVP byte unpacker feeding a tagged pixel stream
module dvp_rx_fsm
    import dvp_rx_pkg::*;
#(
    parameter int DVP_DATA_W = 8,
    parameter int PXL_INFO_W = DVP_DATA_W + 2,
    parameter int BPP        = 2,
    parameter int PXL_W      = DVP_DATA_W * BPP,
    parameter int LINE_CNT_W = 11,
    parameter int FRM_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dcr_cam_start_i,
    dvp_rx_fsm_if.slave           bus,
    output logic                  busy_o,
    output logic [LINE_CNT_W-1:0] line_cnt_o,
    output logic [FRM_CNT_W-1:0]  frm_cnt_o,
    output logic                  frag_err_o
);
    localparam int VSYNC_BIT = vsync_bit(PXL_INFO_W);
    localparam int HSYNC_BIT = hsync_bit(PXL_INFO_W);

    if (!bpp_legal(BPP)) begin : g_bpp_chk
        $error("dvp_rx_fsm: BPP must be in 1..4");
    end

    state_e                state_q, state_d;
    logic [2:0]            byte_idx_q, byte_idx_d;
    logic [PXL_W-1:0]      shift_q, shift_d;
    logic                  sof_pend_q, sof_pend_d;
    logic                  sol_pend_q, sol_pend_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [FRM_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic                  frag_q, frag_d;

    logic                  pxl_rdy, pop, out_free, pix_vld;
    logic                  take, restart_frm, restart_line;
    logic [2:0]            eff_idx;
    logic [PXL_W-1:0]      eff_shift, packed_w;
    logic                  load;
    logic [PXL_W+1:0]      load_word, out_word;
    logic [DVP_DATA_W-1:0] byte_w;
    logic                  vs, hs;

    assign byte_w   = bus.pxl_i[DVP_DATA_W-1:0];
    assign vs       = bus.pxl_i[VSYNC_BIT];
    assign hs       = bus.pxl_i[HSYNC_BIT];
    assign out_free = ~pix_vld | bus.pix_rdy_i;
    assign pop      = bus.pxl_vld_i & pxl_rdy;

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        sof_pend_d   = sof_pend_q;
        sol_pend_d   = sol_pend_q;
        stop_pend_d  = 1'b0;
        line_cnt_d   = line_cnt_q;
        frm_cnt_d    = frm_cnt_q;
        frag_d       = 1'b0;
        pxl_rdy      = 1'b0;
        take         = 1'b0;
        restart_frm  = 1'b0;
        restart_line = 1'b0;
        eff_idx      = byte_idx_q;
        eff_shift    = shift_q;
        packed_w     = '0;
        load         = 1'b0;
        load_word    = '0;

        case (state_q)
            ST_IDLE: begin
                pxl_rdy = 1'b1;
                if (dcr_cam_start_i) state_d = ST_WAIT_FRM;
            end
            ST_WAIT_FRM: begin
                // With BPP=1 the frame-start byte is a whole pixel and needs a free slot.
                pxl_rdy = ~((BPP == 1) && vs && ~out_free);
                if (!dcr_cam_start_i) begin
                    state_d = ST_IDLE;
                end else if (pop && vs) begin
                    take        = 1'b1;
                    restart_frm = 1'b1;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                pxl_rdy     = out_free;
                stop_pend_d = ~dcr_cam_start_i;
                if (pop) begin
                    if (vs) begin
                        frag_d = (byte_idx_q != 3'd0);
                        if (stop_pend_q) begin
                            state_d     = ST_IDLE;
                            byte_idx_d  = 3'd0;
                            sof_pend_d  = 1'b0;
                            sol_pend_d  = 1'b0;
                            stop_pend_d = 1'b0;
                        end else begin
                            take        = 1'b1;
                            restart_frm = 1'b1;
                        end
                    end else if (hs) begin
                        frag_d       = (byte_idx_q != 3'd0);
                        take         = 1'b1;
                        restart_line = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            if (restart_frm | restart_line) begin
                eff_idx    = 3'd0;
                eff_shift  = '0;
                sol_pend_d = 1'b1;
            end
            if (restart_frm) begin
                sof_pend_d = 1'b1;
                line_cnt_d = '0;
                frm_cnt_d  = frm_cnt_q + FRM_CNT_W'(1);
            end
            if (restart_line) line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
            // Earlier bytes move toward the MSBs so the first byte received ends up on top.
            packed_w = (eff_shift << DVP_DATA_W) | PXL_W'(byte_w);
            shift_d  = packed_w;
            if (eff_idx == 3'(BPP - 1)) begin
                load       = 1'b1;
                load_word  = {sof_pend_d, sol_pend_d, packed_w};
                sof_pend_d = 1'b0;
                sol_pend_d = 1'b0;
                byte_idx_d = 3'd0;
            end else begin
                byte_idx_d = eff_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 3'd0;
            shift_q     <= '0;
            sof_pend_q  <= 1'b0;
            sol_pend_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            line_cnt_q  <= '0;
            frm_cnt_q   <= '0;
            frag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            sof_pend_q  <= sof_pend_d;
            sol_pend_q  <= sol_pend_d;
            stop_pend_q <= stop_pend_d;
            line_cnt_q  <= line_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            frag_q      <= frag_d;
        end
    end

    pxl_out_reg #(.W(PXL_W + 2)) u_out (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .data_i (load_word),
        .vld_o  (pix_vld),
        .data_o (out_word),
        .rdy_i  (bus.pix_rdy_i)
    );

    assign bus.pxl_rdy_o = pxl_rdy;
    assign bus.pix_vld_o = pix_vld;
    assign bus.pix_sof_o = out_word[PXL_W+1];
    assign bus.pix_sol_o = out_word[PXL_W];
    assign bus.pix_o     = out_word[PXL_W-1:0];
    assign busy_o        = (state_q != ST_IDLE);
    assign line_cnt_o    = line_cnt_q;
    assign frm_cnt_o     = frm_cnt_q;
    assign frag_err_o    = frag_q;
endmodule
